data_mem_responder: RTL



---
 rtl/mem_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/data_mem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared constants and core-index sizing for the data memory
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int DEF_NUM_CORES  = 2;
  localparam int DEF_REG_WIDTH  = 12;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DEPTH      = 4096;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [idx_width(DEF_NUM_CORES)-1:0] core_idx_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin one-hot arbiter owning its priority pointer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_next;
  logic          w_found;

  // First pass covers cores at or above the pointer, second pass wraps around.
  always_comb begin
    gnt     = '0;
    w_next  = r_ptr;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        gnt[i]  = 1'b1;
        w_next  = (i == N - 1) ? '0 : IW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[i]) begin
        w_found = 1'b1;
        gnt[i]  = 1'b1;
        w_next  = (i == N - 1) ? '0 : IW'(i + 1);
      end
    end
    if (rst) begin
      gnt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder : shared single-port data memory for NUM_CORES cores
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_responder
  import mem_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES-1:0]            wr_en,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CORES*REG_WIDTH-1:0]  wdata,
  output logic [NUM_CORES-1:0]            gnt,
  output logic [NUM_CORES-1:0]            rvalid,
  output logic [NUM_CORES*REG_WIDTH-1:0]  rdata,
  output logic                            busy
);

  localparam int                    MW      = idx_width(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [REG_WIDTH-1:0]  mem [DEPTH];
  logic [REG_WIDTH-1:0]  r_rdata [NUM_CORES];
  logic [NUM_CORES-1:0]  r_rvalid;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [REG_WIDTH-1:0]  w_wdata;
  logic                  w_wr;
  logic                  w_any;
  logic                  w_in_range;
  logic [MW-1:0]         w_maddr;
  logic [REG_WIDTH-1:0]  w_rd;
  logic [3:0]            w_req_cnt;

  rr_arbiter #(
    .N       (NUM_CORES)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (!rst),
    .gnt     (gnt)
  );

  // Route the single granted core onto the memory port.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_wr    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) begin
        w_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = wdata[i*REG_WIDTH +: REG_WIDTH];
        w_wr    = wr_en[i];
      end
    end
  end

  assign w_any      = |gnt;
  assign w_in_range = ({1'b0, w_addr} < DEPTH_L);
  assign w_maddr    = w_addr[MW-1:0];
  assign w_rd       = w_in_range ? mem[w_maddr] : '0;

  always_comb begin
    w_req_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_req_cnt = w_req_cnt + 4'(req[i]);
    end
  end

  assign busy = !rst && (w_req_cnt > 4'd1);

  // Contents survive reset; only the access is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && w_any && w_wr && w_in_range) begin
      mem[w_maddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_rdata[i] <= '0;
      end
    end else begin
      r_rvalid <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (gnt[i] && !wr_en[i]) begin
          r_rvalid[i] <= 1'b1;
          r_rdata[i]  <= w_rd;
        end
      end
    end
  end

  assign rvalid = r_rvalid;

  generate
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_rdata
      assign rdata[g*REG_WIDTH +: REG_WIDTH] = r_rdata[g];
    end
  endgenerate

endmodule

`default_nettype wire
